// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between execute (0) and branch/address (1) requesters.
// Latency: accept at edge E, ALU driven during E..E+1, response registered at E+1.
// Backpressure: a held response blocks only its own requester; the other keeps issuing.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [2:0]      req0_opcode,
    input  logic            req0_signal,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [2:0]      req1_opcode,
    input  logic            req1_signal,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,

    output logic            alu_enable_n,
    output logic [2:0]      alu_opcode,
    output logic            alu_signal,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result
);

    typedef struct packed {
        logic [2:0]      opcode;
        logic            signal;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } alu_op_t;

    alu_op_t req0_op;
    alu_op_t req1_op;
    alu_op_t issue_op;
    logic    issue_valid;
    logic    issue_owner;
    logic    last_grant;

    logic    elig0;
    logic    elig1;
    logic    grant0;
    logic    grant1;

    assign req0_op = {req0_opcode, req0_signal, req0_a, req0_b};
    assign req1_op = {req1_opcode, req1_signal, req1_a, req1_b};

    // A response popped this cycle still blocks its requester until the next cycle.
    always_comb begin
        elig0  = req0_valid && !(issue_valid && !issue_owner) && !rsp0_valid;
        elig1  = req1_valid && !(issue_valid &&  issue_owner) && !rsp1_valid;
        grant0 = elig0 && (!elig1 || last_grant);
        grant1 = elig1 && (!elig0 || !last_grant);
    end

    assign req0_ready = grant0 && !rst;
    assign req1_ready = grant1 && !rst;

    // The issue register is zeroed when idle so the ALU sees quiet inputs.
    assign alu_enable_n = !issue_valid;
    assign alu_opcode   = issue_op.opcode;
    assign alu_signal   = issue_op.signal;
    assign alu_a        = issue_op.a;
    assign alu_b        = issue_op.b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_op    <= '0;
            issue_valid <= 1'b0;
            issue_owner <= 1'b0;
            last_grant  <= 1'b1;
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
        end else begin
            if (grant0) begin
                issue_op    <= req0_op;
                issue_valid <= 1'b1;
                issue_owner <= 1'b0;
                last_grant  <= 1'b0;
            end else if (grant1) begin
                issue_op    <= req1_op;
                issue_valid <= 1'b1;
                issue_owner <= 1'b1;
                last_grant  <= 1'b1;
            end else begin
                issue_op    <= '0;
                issue_valid <= 1'b0;
            end

            // alu_result is only sampled while the issue stage is occupied.
            if (issue_valid && !issue_owner) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= alu_result;
            end else if (rsp0_valid && rsp0_ready) begin
                rsp0_valid  <= 1'b0;
            end

            if (issue_valid && issue_owner) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= alu_result;
            end else if (rsp1_valid && rsp1_ready) begin
                rsp1_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU that floats its result when disabled.
module tb_alu_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid;
    wire  [1:0]       req_ready;
    logic [1:0][2:0]  req_opcode;
    logic [1:0]       req_signal;
    logic [1:0][31:0] req_a;
    logic [1:0][31:0] req_b;
    wire  [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    wire  [1:0][31:0] rsp_result;
    wire              alu_enable_n;
    wire  [2:0]       alu_opcode;
    wire              alu_signal;
    wire  [31:0]      alu_a;
    wire  [31:0]      alu_b;
    wire  [31:0]      alu_result;
    logic [31:0]      alu_model;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_opcode(req_opcode[0]),
        .req0_signal(req_signal[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
        .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_opcode(req_opcode[1]),
        .req1_signal(req_signal[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
        .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_result(rsp_result[0]),
        .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_result(rsp_result[1]),
        .alu_enable_n(alu_enable_n), .alu_opcode(alu_opcode), .alu_signal(alu_signal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
    );

    always_comb begin
        alu_model = 32'h0;
        case (alu_opcode)
            3'd0: alu_model = alu_signal ? alu_a - alu_b : alu_a + alu_b;
            3'd1: alu_model = alu_a << alu_b[4:0];
            3'd2: alu_model = {31'h0, $signed(alu_a) < $signed(alu_b)};
            3'd3: alu_model = {31'h0, alu_a < alu_b};
            3'd4: alu_model = alu_a ^ alu_b;
            3'd5: alu_model = alu_signal ? 32'($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
            3'd6: alu_model = alu_a | alu_b;
            default: alu_model = alu_a & alu_b;
        endcase
    end
    assign alu_result = alu_enable_n ? 32'bz : alu_model;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid  = 2'b00;
        req_opcode = '0;
        req_signal = 2'b00;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 2'b11;
    endtask

    // Leaves the bench 1 ns after a rising edge with reset released.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [2:0] op, input logic sig,
                           input logic [31:0] a, input logic [31:0] b);
        req_opcode[n] = op;
        req_signal[n] = sig;
        req_a[n]      = a;
        req_b[n]      = b;
    endtask

    task automatic run_op(input int n, input logic [2:0] op, input logic sig,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res);
        logic seen;
        seen = 1'b0;
        set_req(n, op, sig, a, b);
        req_valid[n] = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[n]) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check($sformatf("req%0d_ready", n), {31'h0, seen}, 32'h1);
        if (seen) begin
            @(posedge clk);
            #1 req_valid[n] = 1'b0;
            @(negedge clk);
            check($sformatf("op%0d alu_enable_n", n), {31'h0, alu_enable_n}, 32'h0);
            check($sformatf("op%0d alu_opcode", n), {29'h0, alu_opcode}, {29'h0, op});
            check($sformatf("op%0d alu_signal", n), {31'h0, alu_signal}, {31'h0, sig});
            check($sformatf("op%0d alu_a", n), alu_a, a);
            check($sformatf("op%0d alu_b", n), alu_b, b);
            @(negedge clk);
            check($sformatf("op%0d rsp_valid", n), {31'h0, rsp_valid[n]}, 32'h1);
            check($sformatf("op%0d rsp_result", n), rsp_result[n], exp_res);
            @(posedge clk);
            #1;
        end
    endtask

    // Per-cycle expectations for the round-robin and backpressure sequences.
    logic [1:0] rr_ready [6]  = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic       rr_en_n  [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] bp_ready [10] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
    logic       bp_rsp0  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        idle_inputs();
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", {30'h0, req_ready}, 32'h0);
        check("reset rsp_valid", {30'h0, rsp_valid}, 32'h0);
        check("reset rsp0_result", rsp_result[0], 32'h0);
        check("reset rsp1_result", rsp_result[1], 32'h0);
        check("reset alu_enable_n", {31'h0, alu_enable_n}, 32'h1);
        check("reset alu_a", alu_a, 32'h0);
        check("reset alu_b", alu_b, 32'h0);
        check("reset alu_opcode", {29'h0, alu_opcode}, 32'h0);
        do_reset();

        run_op(0, 3'd0, 1'b0, 32'd5, 32'd3, 32'h0000_0008);
        run_op(1, 3'd0, 1'b1, 32'd7, 32'd9, 32'hFFFF_FFFE);
        run_op(1, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000);
        run_op(1, 3'd5, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000);

        // Tie from reset: 0 wins, then the two requesters alternate.
        do_reset();
        set_req(0, 3'd0, 1'b0, 32'd1, 32'd2);
        set_req(1, 3'd4, 1'b0, 32'd10, 32'd4);
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rr%0d ready", i), {30'h0, req_ready}, {30'h0, rr_ready[i]});
            check($sformatf("rr%0d alu_enable_n", i), {31'h0, alu_enable_n}, {31'h0, rr_en_n[i]});
            if (i == 2) check("rr rsp0_result", rsp_result[0], 32'd3);
            if (i == 3) check("rr rsp1_result", rsp_result[1], 32'd14);
            @(posedge clk);
            #1;
        end

        // Requester 0 stalls on its response while requester 1 keeps going.
        do_reset();
        rsp_ready = 2'b10;
        set_req(0, 3'd7, 1'b0, 32'd6, 32'd3);
        set_req(1, 3'd6, 1'b0, 32'd3, 32'd4);
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) rsp_ready[0] = 1'b1;
            @(negedge clk);
            check($sformatf("bp%0d ready", i), {30'h0, req_ready}, {30'h0, bp_ready[i]});
            check($sformatf("bp%0d rsp0_valid", i), {31'h0, rsp_valid[0]}, {31'h0, bp_rsp0[i]});
            if (bp_rsp0[i]) check($sformatf("bp%0d rsp0_result", i), rsp_result[0], 32'd2);
            if (i == 3) check("bp rsp1_result", rsp_result[1], 32'd7);
            @(posedge clk);
            #1;
        end

        // Nothing requested: ALU stays disabled and quiet while its result floats.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d alu_enable_n", i), {31'h0, alu_enable_n}, 32'h1);
            check($sformatf("idle%0d alu_ab", i), alu_a | alu_b, 32'h0);
            check($sformatf("idle%0d rsp_valid", i), {30'h0, rsp_valid}, 32'h0);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between accept and capture discards the op.
        do_reset();
        set_req(0, 3'd0, 1'b0, 32'd20, 32'd22);
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        #2;
        check("mid alu_enable_n before rst", {31'h0, alu_enable_n}, 32'h0);
        rst = 1'b1;
        #1;
        check("mid alu_enable_n", {31'h0, alu_enable_n}, 32'h1);
        check("mid alu_a", alu_a, 32'h0);
        check("mid rsp_valid", {30'h0, rsp_valid}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mid%0d rsp_valid", i), {30'h0, rsp_valid}, 32'h0);
            @(posedge clk);
            #1;
        end
        set_req(1, 3'd6, 1'b0, 32'd1, 32'd1);
        req_valid = 2'b11;
        @(negedge clk);
        check("mid tie ready", {30'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 2'b00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
